// File: rtl/tcount_ctrl_pkg.sv
// tcount_ctrl shared constants and helpers.
// Per-instance limits are derived from these at elaboration.
package tcount_ctrl_pkg;

  localparam int MAX_WIDTH = 16;

  function automatic int max_cnt(input int mod);
    return mod - 1;
  endfunction

  function automatic bit is_pow2(
    input int mod,
    input int width
  );
    return mod == (1 << width);
  endfunction

  // Out-of-range load values clamp to the terminal value.
  function automatic logic [MAX_WIDTH-1:0] sat_load(
    input logic [MAX_WIDTH-1:0] din,
    input int                   mod
  );
    if (32'(din) < 32'(mod))
      return din;
    return MAX_WIDTH'(mod - 1);
  endfunction

endpackage

// File: rtl/tcount_ctrl_if.sv
// tcount_ctrl control/status bundle.
// The master drives count controls, the slave returns count state.
interface tcount_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up, load, din,
    input  q, tc, wrap
  );

  modport slave (
    input  en, up, load, din,
    output q, tc, wrap
  );
endinterface

// File: rtl/tcount_ctrl_tcell.sv
// tcell: one T-type storage bit with synchronous clear.
// Holds unless t is high, in which case it inverts.
module tcell (
  input  logic clk,
  input  logic clr,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (clr)
      q <= 1'b0;
    else if (t)
      q <= ~q;
  end

endmodule

// File: rtl/tcount_ctrl.sv
// tcount_ctrl: modulo up/down counter that generates the
// toggle enables for a chain of T storage cells.
module tcount_ctrl
  import tcount_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic         clk,
  input  logic         clr,
  tcount_ctrl_if.slave bus
);

  localparam int MAX_CNT = max_cnt(MOD);
  localparam bit POW2    = is_pow2(MOD, WIDTH);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX_CNT);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("tcount_ctrl: WIDTH out of range");
  end
  if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
    $error("tcount_ctrl: MOD out of range");
  end

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] t;
  logic             over;
  logic             at_top;
  logic             at_bot;
  logic             ld;
  logic             inc;
  logic             dec;
  logic             wrap_nxt;
  logic             wrap;

  // Corrupted values above TOP count as terminal both ways.
  assign over   = (q >= TOP) && (q != TOP);
  assign at_top = (q == TOP) || over;
  assign at_bot = (q == '0) || over;

  assign ld  = bus.load;
  assign inc = !bus.load && bus.en && bus.up;
  assign dec = !bus.load && bus.en && !bus.up;

  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    unique case (1'b1)
      ld: begin
        q_nxt = WIDTH'(sat_load(MAX_WIDTH'(bus.din), MOD));
      end
      inc: begin
        q_nxt    = (POW2 || !at_top) ? q + WIDTH'(1) : '0;
        wrap_nxt = at_top;
      end
      dec: begin
        q_nxt    = (POW2 || !at_bot) ? q - WIDTH'(1) : TOP;
        wrap_nxt = at_bot;
      end
      default: begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
      end
    endcase
  end

  assign t = q ^ q_nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tcell u_cell (
      .clk (clk),
      .clr (clr),
      .t   (t[i]),
      .q   (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (clr)
      wrap <= 1'b0;
    else
      wrap <= wrap_nxt;
  end

  assign bus.q    = q;
  assign bus.wrap = wrap;
  assign bus.tc   = bus.en &
                    (bus.up ? (q == TOP) : (q == '0));

endmodule

// File: tb/tb_tcount_ctrl.sv
// tb_tcount_ctrl: three counter configurations driven by shared
// directed and random stimulus, checked against a modular model.
module tb_tcount_ctrl;

  localparam int MODV [3] = '{10, 8, 2};
  localparam int MSKV [3] = '{15, 7, 3};

  logic       clk = 1'b0;
  logic       clr;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] din;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tcount_ctrl_if #(.WIDTH(4)) ia ();
  tcount_ctrl_if #(.WIDTH(3)) ib ();
  tcount_ctrl_if #(.WIDTH(2)) ic ();

  assign ia.en = en;  assign ia.up = up;
  assign ib.en = en;  assign ib.up = up;
  assign ic.en = en;  assign ic.up = up;
  assign ia.load = load;
  assign ib.load = load;
  assign ic.load = load;
  assign ia.din = din;
  assign ib.din = din[2:0];
  assign ic.din = din[1:0];

  tcount_ctrl #(.WIDTH(4), .MOD(10)) dut_a (
    .clk(clk), .clr(clr), .bus(ia));
  tcount_ctrl #(.WIDTH(3), .MOD(8)) dut_b (
    .clk(clk), .clr(clr), .bus(ib));
  tcount_ctrl #(.WIDTH(2), .MOD(2)) dut_c (
    .clk(clk), .clr(clr), .bus(ic));

  logic [15:0] act_q [3];
  logic [15:0] act_t [3];
  logic        act_w [3];
  logic        act_tc[3];

  assign act_q[0] = 16'(ia.q);
  assign act_q[1] = 16'(ib.q);
  assign act_q[2] = 16'(ic.q);
  assign act_t[0] = 16'(dut_a.t);
  assign act_t[1] = 16'(dut_b.t);
  assign act_t[2] = 16'(dut_c.t);
  assign act_w[0] = ia.wrap;
  assign act_w[1] = ib.wrap;
  assign act_w[2] = ic.wrap;
  assign act_tc[0] = ia.tc;
  assign act_tc[1] = ib.tc;
  assign act_tc[2] = ic.tc;

  int m_q [3];
  bit m_w [3];
  bit started = 1'b0;

  task automatic chk(
    input string       nm,
    input logic [15:0] act,
    input logic [15:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Next count of configuration k under the present inputs.
  function automatic int nxt(input int k, output bit w);
    int d;
    d = int'(din) & MSKV[k];
    w = 1'b0;
    if (load)
      return (d < MODV[k]) ? d : MODV[k] - 1;
    if (!en)
      return m_q[k];
    if (up) begin
      w = (m_q[k] == MODV[k] - 1);
      return (m_q[k] + 1) % MODV[k];
    end
    w = (m_q[k] == 0);
    return (m_q[k] + MODV[k] - 1) % MODV[k];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit w;
      int n;
      n = nxt(k, w);
      if (clr) begin
        m_q[k] = 0;
        m_w[k] = 1'b0;
      end else begin
        m_q[k] = n;
        m_w[k] = w;
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        bit w;
        int n;
        bit tce;
        tce = en && (up ? (m_q[k] == MODV[k] - 1)
                        : (m_q[k] == 0));
        chk($sformatf("q%0d", k), act_q[k], 16'(m_q[k]));
        chk($sformatf("wrap%0d", k), 16'(act_w[k]), 16'(m_w[k]));
        chk($sformatf("tc%0d", k), 16'(act_tc[k]), 16'(tce));
        if (!clr) begin
          n = nxt(k, w);
          chk($sformatf("t%0d", k), act_t[k],
              16'(n ^ m_q[k]));
        end
      end
    end
  end

  task automatic drive(
    input bit         c,
    input bit         l,
    input bit         e,
    input bit         u,
    input logic [3:0] d
  );
    clr  = c;
    load = l;
    en   = e;
    up   = u;
    din  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_up [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

  initial begin
    drive(1, 1, 1, 1, 4'd7);
    repeat (2) begin
      tick();
      chk("rst_q", 16'(ia.q), 16'd0);
      chk("rst_wrap", 16'(ia.wrap), 16'd0);
    end

    drive(0, 0, 1, 1, 4'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("up_q", 16'(ia.q), 16'(exp_up[i]));
      chk("up_wrap", 16'(ia.wrap), 16'(i == 9));
      chk("up_tc", 16'(ia.tc), 16'(exp_up[i] == 9));
    end

    drive(0, 1, 1, 1, 4'd1);
    tick();
    chk("ld1_q", 16'(ia.q), 16'd1);
    drive(0, 0, 1, 0, 4'd0);
    #1 chk("dn_tc1", 16'(ia.tc), 16'd0);
    tick();
    chk("dn_q0", 16'(ia.q), 16'd0);
    chk("dn_tc0", 16'(ia.tc), 16'd1);
    tick();
    chk("dn_q9", 16'(ia.q), 16'd9);
    chk("dn_wrap", 16'(ia.wrap), 16'd1);
    tick();
    chk("dn_q8", 16'(ia.q), 16'd8);
    chk("dn_wrap8", 16'(ia.wrap), 16'd0);

    drive(0, 1, 0, 0, 4'd6);
    tick();
    chk("ld6", 16'(ia.q), 16'd6);
    drive(0, 1, 0, 0, 4'd13);
    tick();
    chk("ld13_sat", 16'(ia.q), 16'd9);
    drive(0, 1, 1, 1, 4'd3);
    #1 chk("ld_tc9", 16'(ia.tc), 16'd1);
    tick();
    chk("ld_en_q", 16'(ia.q), 16'd3);
    chk("ld_en_wrap", 16'(ia.wrap), 16'd0);

    drive(0, 1, 0, 0, 4'd5);
    tick();
    drive(0, 0, 0, 1, 4'd5);
    repeat (5) begin
      #1 chk("hold_t", 16'(dut_a.t), 16'd0);
      tick();
      chk("hold_q", 16'(ia.q), 16'd5);
    end

    drive(0, 1, 0, 0, 4'd7);
    tick();
    drive(0, 0, 1, 1, 4'd0);
    #1 chk("t_7to8", 16'(dut_a.t), 16'b1111);
    tick();
    chk("q_8", 16'(ia.q), 16'd8);
    chk("t_8to9", 16'(dut_a.t), 16'b0001);
    tick();
    chk("q_9", 16'(ia.q), 16'd9);

    drive(0, 1, 0, 0, 4'd7);
    tick();
    chk("p2_ld7", 16'(ib.q), 16'd7);
    chk("m2_ldsat", 16'(ic.q), 16'd1);
    drive(0, 0, 1, 1, 4'd0);
    tick();
    chk("p2_up_q", 16'(ib.q), 16'd0);
    chk("p2_up_wrap", 16'(ib.wrap), 16'd1);
    drive(0, 0, 1, 0, 4'd0);
    tick();
    chk("p2_dn_q", 16'(ib.q), 16'd7);
    chk("p2_dn_wrap", 16'(ib.wrap), 16'd1);

    drive(1, 0, 0, 0, 4'd0);
    tick();
    drive(0, 0, 1, 1, 4'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("m2_q", 16'(ic.q), 16'((i % 2) == 0));
      chk("m2_wrap", 16'(ic.wrap), 16'((i % 2) == 1));
    end

    repeat (2000) begin
      drive($urandom_range(0, 31) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)));
      tick();
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
